// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - parameterised up/down counter with wrap/saturate bounds, load and overflow/underflow flags
module updown_counter_param #(
  parameter int WIDTH     = 4,
  parameter int MIN_VAL   = 0,
  parameter int MAX_VAL   = 2**WIDTH - 1,
  parameter int STEP      = 1,
  parameter bit WRAP      = 1'b1,
  parameter int RESET_VAL = MIN_VAL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             increment,
  input  logic             decrement,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             ovf_pulse,
  output logic             unf_pulse,
  output logic             ovf_sticky,
  output logic             unf_sticky
);

  // One extra bit keeps count+STEP and the wrap remainders from truncating.
  localparam logic [WIDTH:0] MIN_E  = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0] MAX_E  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] STEP_E = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);

  logic [WIDTH:0] cnt_ext;
  logic [WIDTH:0] load_ext;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] span;
  logic [WIDTH:0] count_nxt;
  logic           ovf_evt;
  logic           unf_evt;

  always_comb begin
    cnt_ext   = {1'b0, count};
    load_ext  = {1'b0, load_val};
    sum       = cnt_ext + STEP_E;
    span      = cnt_ext - MIN_E;
    count_nxt = cnt_ext;
    ovf_evt   = 1'b0;
    unf_evt   = 1'b0;

    if (load) begin
      if (load_ext > MAX_E) begin
        count_nxt = MAX_E;
      end else if (load_ext < MIN_E) begin
        count_nxt = MIN_E;
      end else begin
        count_nxt = load_ext;
      end
    end else if (increment && !decrement) begin
      if (sum <= MAX_E) begin
        count_nxt = sum;
      end else begin
        ovf_evt = 1'b1;
        if (WRAP) begin
          count_nxt = MIN_E + (sum - MAX_E - 1'b1);
        end else begin
          count_nxt = MAX_E;
        end
      end
    end else if (decrement && !increment) begin
      if (span >= STEP_E) begin
        count_nxt = cnt_ext - STEP_E;
      end else begin
        unf_evt = 1'b1;
        if (WRAP) begin
          count_nxt = MAX_E - (STEP_E - span - 1'b1);
        end else begin
          count_nxt = MIN_E;
        end
      end
    end
  end

  // A new event beats a simultaneous clear so no overflow is ever lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= RESET_W;
      ovf_pulse  <= 1'b0;
      unf_pulse  <= 1'b0;
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
    end else begin
      count      <= WIDTH'(count_nxt);
      ovf_pulse  <= ovf_evt;
      unf_pulse  <= unf_evt;
      ovf_sticky <= ovf_evt | (ovf_sticky & ~clear_flags);
      unf_sticky <= unf_evt | (unf_sticky & ~clear_flags);
    end
  end

  assign at_max = (count == WIDTH'(MAX_VAL));
  assign at_min = (count == WIDTH'(MIN_VAL));

endmodule

// File: tb/tb_updown_counter_param.sv
// tb/tb_updown_counter_param.sv - bench running four counter configurations against a range-arithmetic model
module tb_updown_counter_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       increment = 1'b0;
  logic       decrement = 1'b0;
  logic       clear_flags = 1'b0;

  logic [3:0] cnt [4];
  logic       amax [4];
  logic       amin [4];
  logic       op [4];
  logic       up [4];
  logic       os [4];
  logic       us [4];

  // 0: defaults, 1: 2..12 step 3 wrap, 2: defaults saturating, 3: 2..12 step 1 saturating
  int p_min  [4] = '{0, 2, 0, 2};
  int p_max  [4] = '{15, 12, 15, 12};
  int p_step [4] = '{1, 3, 1, 1};
  int p_wrap [4] = '{1, 1, 0, 0};

  int m_cnt [4];
  bit m_op [4];
  bit m_up [4];
  bit m_os [4];
  bit m_us [4];

  int errors = 0;
  int checks = 0;

  updown_counter_param #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(15), .STEP(1), .WRAP(1'b1), .RESET_VAL(0)) u0 (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .increment(increment),
    .decrement(decrement), .clear_flags(clear_flags), .count(cnt[0]), .at_max(amax[0]), .at_min(amin[0]),
    .ovf_pulse(op[0]), .unf_pulse(up[0]), .ovf_sticky(os[0]), .unf_sticky(us[0]));

  updown_counter_param #(.WIDTH(4), .MIN_VAL(2), .MAX_VAL(12), .STEP(3), .WRAP(1'b1), .RESET_VAL(2)) u1 (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .increment(increment),
    .decrement(decrement), .clear_flags(clear_flags), .count(cnt[1]), .at_max(amax[1]), .at_min(amin[1]),
    .ovf_pulse(op[1]), .unf_pulse(up[1]), .ovf_sticky(os[1]), .unf_sticky(us[1]));

  updown_counter_param #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(15), .STEP(1), .WRAP(1'b0), .RESET_VAL(0)) u2 (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .increment(increment),
    .decrement(decrement), .clear_flags(clear_flags), .count(cnt[2]), .at_max(amax[2]), .at_min(amin[2]),
    .ovf_pulse(op[2]), .unf_pulse(up[2]), .ovf_sticky(os[2]), .unf_sticky(us[2]));

  updown_counter_param #(.WIDTH(4), .MIN_VAL(2), .MAX_VAL(12), .STEP(1), .WRAP(1'b0), .RESET_VAL(2)) u3 (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .increment(increment),
    .decrement(decrement), .clear_flags(clear_flags), .count(cnt[3]), .at_max(amax[3]), .at_min(amin[3]),
    .ovf_pulse(op[3]), .unf_pulse(up[3]), .ovf_sticky(os[3]), .unf_sticky(us[3]));

  // Reference: the count is an offset into a ring (or clamp) of size max-min+1.
  function automatic void model_step(int i);
    int rng;
    int c;
    bit o;
    bit u;
    rng = p_max[i] - p_min[i] + 1;
    c = m_cnt[i];
    o = 1'b0;
    u = 1'b0;
    if (reset) begin
      m_cnt[i] = p_min[i];
      m_op[i] = 0; m_up[i] = 0; m_os[i] = 0; m_us[i] = 0;
      return;
    end
    if (load) begin
      c = int'(load_val);
      if (c > p_max[i]) c = p_max[i];
      if (c < p_min[i]) c = p_min[i];
    end else if (increment && !decrement) begin
      if (c + p_step[i] > p_max[i]) begin
        o = 1'b1;
        c = p_wrap[i] != 0 ? p_min[i] + (c - p_min[i] + p_step[i]) % rng : p_max[i];
      end else begin
        c = c + p_step[i];
      end
    end else if (decrement && !increment) begin
      if (c - p_step[i] < p_min[i]) begin
        u = 1'b1;
        c = p_wrap[i] != 0 ? p_min[i] + (c - p_min[i] - p_step[i] + rng) % rng : p_min[i];
      end else begin
        c = c - p_step[i];
      end
    end
    m_cnt[i] = c;
    m_op[i] = o;
    m_up[i] = u;
    m_os[i] = o | (m_os[i] & !clear_flags);
    m_us[i] = u | (m_us[i] & !clear_flags);
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 4; i++) model_step(i);
    #1;
  endtask

  task automatic idle();
    reset = 0; load = 0; increment = 0; decrement = 0; clear_flags = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cnt[i] !== 4'(p_min[i]) || op[i] !== 0 || up[i] !== 0 || os[i] !== 0 || us[i] !== 0) begin
        errors++;
        $display("FAIL reset dut%0d: count=%0d flags=%b%b%b%b required count=%0d flags=0000",
                 i, cnt[i], op[i], up[i], os[i], us[i], p_min[i]);
      end
    end
  endtask

  task automatic test_count_up_down();
    int exp_up [3] = '{1, 2, 3};
    checks++;
    if (cnt[0] !== 4'd0) begin
      errors++; $display("FAIL up_start: count=%0d required 0", cnt[0]);
    end
    increment = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (cnt[0] !== 4'(exp_up[k])) begin
        errors++; $display("FAIL up_step%0d: count=%0d required %0d", k, cnt[0], exp_up[k]);
      end
    end
    increment = 0; decrement = 1;
    tick();
    decrement = 0;
    checks++;
    if (cnt[0] !== 4'd2 || op[0] !== 0 || up[0] !== 0 || os[0] !== 0 || us[0] !== 0) begin
      errors++; $display("FAIL down_step: count=%0d flags=%b%b%b%b required 2 and 0000",
                         cnt[0], op[0], up[0], os[0], us[0]);
    end
  endtask

  task automatic test_wrap();
    load = 1; load_val = 4'd11;
    tick();
    load = 0; increment = 1;
    tick();
    increment = 0;
    checks++;
    if (cnt[1] !== 4'd3 || op[1] !== 1 || os[1] !== 1) begin
      errors++; $display("FAIL wrap_ovf: count=%0d op=%b os=%b required 3 1 1", cnt[1], op[1], os[1]);
    end
    tick();
    checks++;
    if (op[1] !== 0 || os[1] !== 1 || cnt[1] !== 4'd3) begin
      errors++; $display("FAIL wrap_ovf_pulse_end: count=%0d op=%b os=%b required 3 0 1", cnt[1], op[1], os[1]);
    end
    decrement = 1;
    tick();
    decrement = 0;
    checks++;
    if (cnt[1] !== 4'd11 || up[1] !== 1 || us[1] !== 1) begin
      errors++; $display("FAIL wrap_unf: count=%0d up=%b us=%b required 11 1 1", cnt[1], up[1], us[1]);
    end
  endtask

  task automatic test_saturate();
    load = 1; load_val = 4'd15;
    tick();
    load = 0; increment = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (cnt[2] !== 4'd15 || amax[2] !== 1 || op[2] !== 1) begin
        errors++; $display("FAIL sat_ovf%0d: count=%0d at_max=%b op=%b required 15 1 1", k, cnt[2], amax[2], op[2]);
      end
    end
    clear_flags = 1;
    tick();
    checks++;
    if (os[2] !== 1) begin
      errors++; $display("FAIL sat_set_beats_clear: os=%b required 1", os[2]);
    end
    increment = 0;
    tick();
    clear_flags = 0;
    checks++;
    if (os[2] !== 0 || op[2] !== 0) begin
      errors++; $display("FAIL sat_clear: os=%b op=%b required 0 0", os[2], op[2]);
    end
  endtask

  task automatic test_clamp();
    load = 1; load_val = 4'd14; increment = 1;
    tick();
    increment = 0;
    checks++;
    if (cnt[3] !== 4'd12 || op[3] !== 0 || os[3] !== 0 || amax[3] !== 1) begin
      errors++; $display("FAIL clamp_high: count=%0d op=%b os=%b at_max=%b required 12 0 0 1",
                         cnt[3], op[3], os[3], amax[3]);
    end
    load_val = 4'd0;
    tick();
    load = 0;
    checks++;
    if (cnt[3] !== 4'd2 || amin[3] !== 1) begin
      errors++; $display("FAIL clamp_low: count=%0d at_min=%b required 2 1", cnt[3], amin[3]);
    end
  endtask

  task automatic test_simultaneous();
    load = 1; load_val = 4'd5;
    tick();
    load = 0; increment = 1; decrement = 1;
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cnt[i] !== 4'd5 || op[i] !== 0 || up[i] !== 0) begin
        errors++; $display("FAIL simultaneous dut%0d: count=%0d op=%b up=%b required 5 0 0", i, cnt[i], op[i], up[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    load = 1; load_val = 4'd15;
    tick();
    load = 0; increment = 1;
    tick();
    increment = 0; load = 1; load_val = 4'd7;
    tick();
    load = 0;
    checks++;
    if (cnt[2] !== 4'd7 || os[2] !== 1) begin
      errors++; $display("FAIL reset_mid_setup: count=%0d os=%b required 7 1", cnt[2], os[2]);
    end
    reset = 1; increment = 1;
    tick();
    reset = 0;
    checks++;
    if (cnt[2] !== 4'd0 || os[2] !== 0 || op[2] !== 0 || us[2] !== 0 || up[2] !== 0) begin
      errors++; $display("FAIL reset_mid: count=%0d flags=%b%b%b%b required 0 and 0000",
                         cnt[2], op[2], up[2], os[2], us[2]);
    end
    tick();
    increment = 0;
    checks++;
    if (cnt[2] !== 4'd1) begin
      errors++; $display("FAIL reset_resume: count=%0d required 1", cnt[2]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      reset       = ($urandom_range(0, 99) < 2);
      load        = ($urandom_range(0, 99) < 10);
      load_val    = 4'($urandom_range(0, 15));
      increment   = ($urandom_range(0, 99) < 50);
      decrement   = ($urandom_range(0, 99) < 40);
      clear_flags = ($urandom_range(0, 99) < 10);
      tick();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cnt[i] !== 4'(m_cnt[i]) || op[i] !== m_op[i] || up[i] !== m_up[i] ||
            os[i] !== m_os[i] || us[i] !== m_us[i] ||
            amax[i] !== (m_cnt[i] == p_max[i]) || amin[i] !== (m_cnt[i] == p_min[i])) begin
          errors++;
          $display("FAIL random n=%0d dut%0d: count=%0d op/up/os/us=%b%b%b%b max/min=%b%b required count=%0d flags=%b%b%b%b",
                   n, i, cnt[i], op[i], up[i], os[i], us[i], amax[i], amin[i],
                   m_cnt[i], m_op[i], m_up[i], m_os[i], m_us[i]);
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_count_up_down();
    test_wrap();
    test_saturate();
    test_clamp();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
